vproc_div_iter: RTL and testbench

Iterative radix-2 integer divide engine that serves requests issued by the vector divide unit's operand stage, and returns quotient or remainder through a valid/ready result port. It implements RISC-V M-extension semantics for DIV/DIVU/REM/REMU, including the divide-by-zero and signed-overflow cases. It processes one element per request and uses one restoring-division step per cycle. It sits between the divide unit's `pipe_in` buffer and its `pipe_out` result buffer.

---
 rtl/vproc_div_iter.sv | 120 ++++++++++++
 tb/tb_vproc_div_iter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vproc_div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU, RISC-V semantics), one element per request.
// Latency WIDTH+1 cycles (1 for divide-by-zero/overflow); result held in DONE until out_ready_i.
module vproc_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             async_rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [WIDTH-1:0] in_dividend_i,
  input  logic [WIDTH-1:0] in_divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic             is_rem_q;
  logic             neg_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             signed_op, dvd_neg, dsr_neg, div_zero, overflow, special;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, special_res;
  logic [WIDTH:0]   partial, diff;
  logic             ge, last;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, res_raw, res_fix;

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    signed_op = in_op_i[0];
    dvd_neg   = signed_op & in_dividend_i[WIDTH-1];
    dsr_neg   = signed_op & in_divisor_i[WIDTH-1];
    // The most negative value negates onto itself, which is already its unsigned magnitude.
    dvd_mag   = dvd_neg ? -in_dividend_i : in_dividend_i;
    dsr_mag   = dsr_neg ? -in_divisor_i : in_divisor_i;
    div_zero  = (in_divisor_i == '0);
    overflow  = signed_op && (in_dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&in_divisor_i);
    special   = div_zero || overflow;
    if (div_zero) special_res = in_op_i[1] ? in_dividend_i : '1;
    else          special_res = in_op_i[1] ? '0 : in_dividend_i;
  end

  // One restoring step; the borrow of the WIDTH+1-bit difference is the compare result.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dsr_q};
    ge      = ~diff[WIDTH];
    rem_nxt = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
    res_raw = is_rem_q ? rem_nxt : quo_nxt;
    res_fix = neg_q ? -res_raw : res_raw;
    last    = (cnt_q == CNT_W'(WIDTH-1));
  end

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (accept) state_d = special ? DONE : CALC;
      end
      CALC: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          if (accept) state_d = special ? DONE : CALC;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= '0;
        quo_q    <= dvd_mag;
        rem_q    <= '0;
        dsr_q    <= dsr_mag;
        is_rem_q <= in_op_i[1];
        neg_q    <= in_op_i[1] ? dvd_neg : (dvd_neg ^ dsr_neg);
        if (special) result_q <= special_res;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
        quo_q <= quo_nxt;
        rem_q <= rem_nxt;
        if (last) result_q <= res_fix;
      end
    end
  end

  assign out_valid_o  = (state_q == DONE);
  assign out_result_o = result_q;

endmodule

// File: tb/tb_vproc_div_iter.sv
// Directed-vector and reference-model bench for vproc_div_iter at WIDTH=32.
module tb_vproc_div_iter;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_dividend, in_divisor, out_result;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vproc_div_iter #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .async_rst_ni (async_rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_dividend_i(in_dividend),
    .in_divisor_i (in_divisor),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vec[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0)
      r = op[1] ? a : 32'hFFFF_FFFF;
    else if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      r = op[1] ? 32'd0 : a;
    else begin
      case (op)
        2'd0:    r = a / b;
        2'd1:    r = $signed(a) / $signed(b);
        2'd2:    r = a % b;
        default: r = $signed(a) % $signed(b);
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Presents a request at a negedge and holds it until it is accepted on a rising edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int tries = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_dividend = a; in_divisor = b;
    #1;
    while (!in_ready && tries < 100) begin
      @(negedge clk); #1;
      tries++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_dividend = 32'hDEAD_BEEF;
    in_divisor  = 32'h0000_0003;
  endtask

  // Counts cycles to out_valid, checks result and latency, then lets the handshake complete.
  task automatic wait_res(input string name, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    int busy_rdy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) busy_rdy++;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_res"}, out_result, exp);
    if (exp_lat > 1) chk({name, "_busy_rdy"}, busy_rdy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec[0]  = '{2'd0, 32'd100,        32'd7,          32'd14,         33};
    vec[1]  = '{2'd1, -32'd7,         32'd2,          32'hFFFF_FFFD,  33};
    vec[2]  = '{2'd3, -32'd7,         32'd2,          32'hFFFF_FFFF,  33};
    vec[3]  = '{2'd3, 32'd7,          -32'd2,         32'd1,          33};
    vec[4]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'd1,          33};
    vec[5]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vec[6]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1};
    vec[7]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vec[8]  = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vec[9]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vec[10] = '{2'd0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vec[11] = '{2'd1, 32'h8000_0000,  32'd1,          32'h8000_0000,  33};
    vec[12] = '{2'd2, 32'd0,          32'd0,          32'd0,          1};
    vec[13] = '{2'd1, -32'd100,       -32'd7,         32'd14,         33};
    vec[14] = '{2'd3, -32'd100,       -32'd7,         32'hFFFF_FFFE,  33};

    async_rst_n = 1'b0;
    in_valid = 1'b0; in_op = 2'd0; in_dividend = 32'd0; in_divisor = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", out_result, 32'd0);
    async_rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      start_op(vec[i].op, vec[i].a, vec[i].b);
      wait_res($sformatf("vec%0d", i), vec[i].exp, vec[i].lat);
    end

    // Backpressure, then a new request accepted in the handshake cycle.
    out_ready = 1'b0;
    start_op(2'd0, 32'd1000, 32'd10);
    begin
      int lat = 0;
      while (lat < 100 && !out_valid) begin
        @(negedge clk);
        lat++;
      end
      chk("bp_lat", lat, 33);
      chk("bp_res", out_result, 32'd100);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_res", out_result, 32'd100);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'd0; in_dividend = 32'd77; in_divisor = 32'd7;
    #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_dividend = 32'hDEAD_BEEF;
    wait_res("b2b", 32'd11, 33);

    // Reset during iteration 10 of a normal divide.
    start_op(2'd0, 32'hFFFF_0000, 32'd3);
    repeat (10) @(negedge clk);
    #2 async_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_result", out_result, 32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
    begin
      int spurious = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) spurious++;
      end
      chk("midrst_spurious", spurious, 0);
    end
    start_op(2'd0, 32'd9, 32'd3);
    wait_res("post_rst", 32'd3, 33);

    // Randomised sweep against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          lat;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      lat = (b == 32'd0 || (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      start_op(op, a, b);
      wait_res($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), ref_model(op, a, b), lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
